conv_sched: RTL

CONV_SCHED -- requirements
Module: conv_sched

---
 rtl/conv_sched_pkg.sv | 17 +
 rtl/conv_sched_delay.sv | 41 ++++
 rtl/conv_sched.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg: shared state encoding and default widths/latencies for the
// convolution scheduler and its delay line.
package conv_sched_pkg;

   localparam int unsigned NB_ADDRESS_DEF = 10;  // default memory address width
   localparam int unsigned CONV_LAT_DEF   = 3;   // default convolver latency
   localparam int unsigned NB_BLK         = 8;   // block count / index width

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_NEXT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/conv_sched_delay.sv
// sched_delay: DEPTH-stage shift register carrying a valid flag and a row
// index; flush_i drops every in-flight valid in one cycle.
// Ports: clk_i, rst_i (async, active-high), flush_i, valid_i/idx_i (input
// stage), valid_o/idx_o (last stage, registered).
module sched_delay #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned IDX_W = 10
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             valid_i,
   input  logic [IDX_W-1:0] idx_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [DEPTH-1:0] vld_q;
   logic [IDX_W-1:0] idx_q [DEPTH];

   // Shift stage; index bits need no flush since valid gates their use.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) idx_q[i] <= '0;
      end else if (flush_i) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= valid_i;
         idx_q[0] <= idx_i;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            idx_q[i] <= idx_q[i-1];
         end
      end
   end

   assign valid_o = vld_q[DEPTH-1];
   assign idx_o   = idx_q[DEPTH-1];

endmodule

// File: rtl/conv_sched.sv
// conv_sched: sequences row reads for B column blocks of an L-row image,
// drives convolver valid, and issues result writes once the convolver
// latency has elapsed.
// Ports: i_CLK, i_reset (async, active-high), i_start, i_abort,
//   i_imgLength (L), i_nblocks (B) in; o_readAdd, o_writeAdd, o_we,
//   o_conv_valid, o_sop, o_chblk, o_eop, o_busy, o_err, o_blk_idx out.
module conv_sched
   import conv_sched_pkg::*;
#(
   parameter int unsigned NB_ADDRESS = NB_ADDRESS_DEF,
   parameter int unsigned N_CONV     = 2,
   parameter int unsigned CONV_LAT   = CONV_LAT_DEF
) (
   input  logic                  i_CLK,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic [NB_ADDRESS-1:0] i_imgLength,
   input  logic [NB_BLK-1:0]     i_nblocks,
   output logic [NB_ADDRESS-1:0] o_readAdd,
   output logic [NB_ADDRESS-1:0] o_writeAdd,
   output logic                  o_we,
   output logic                  o_conv_valid,
   output logic                  o_sop,
   output logic                  o_chblk,
   output logic                  o_eop,
   output logic                  o_busy,
   output logic                  o_err,
   output logic [NB_BLK-1:0]     o_blk_idx
);

   localparam int unsigned DLY_DEPTH = CONV_LAT + 1;
   localparam int unsigned CNT_W     = $clog2(CONV_LAT + 1) + 1;

   state_t                state_q, state_d;
   logic [NB_ADDRESS-1:0] read_q, read_d;
   logic [NB_ADDRESS-1:0] len_q, len_d;
   logic [NB_BLK-1:0]     nblk_q, nblk_d;
   logic [NB_BLK-1:0]     blk_q, blk_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  sop_q, sop_d;
   logic                  chblk_q, chblk_d;
   logic                  eop_q, eop_d;
   logic                  busy_q, busy_d;
   logic                  cval_q, cval_d;
   logic                  cfg_ok_c;
   logic                  dly_flush_c;
   logic                  dly_in_c;

   // A configuration with no convolver lanes cannot accept any job.
   assign cfg_ok_c = (i_imgLength >= NB_ADDRESS'(3)) && (i_nblocks != '0)
                     && (N_CONV >= 32'd1);

   // Next-state and pulse generation.
   always_comb begin
      state_d = state_q;
      read_d  = read_q;
      len_d   = len_q;
      nblk_d  = nblk_q;
      blk_d   = blk_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      sop_d   = 1'b0;
      chblk_d = 1'b0;
      eop_d   = 1'b0;
      if (i_abort) begin
         // Abort beats everything, including a coincident start in IDLE.
         if (state_q != ST_IDLE) state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  len_d  = i_imgLength;
                  nblk_d = i_nblocks;
                  if (cfg_ok_c) begin
                     state_d = ST_RUN;
                     sop_d   = 1'b1;
                     read_d  = '0;
                     blk_d   = '0;
                     err_d   = 1'b0;
                  end else begin
                     state_d = ST_DONE;
                     eop_d   = 1'b1;
                     err_d   = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (read_q == len_q - NB_ADDRESS'(1)) begin
                  state_d = ST_DRAIN;
                  cnt_d   = '0;
               end else begin
                  read_d = read_q + NB_ADDRESS'(1);
               end
            end
            ST_DRAIN: begin
               // Last read needs CONV_LAT+1 cycles to leave the delay line.
               if (cnt_q == CNT_W'(CONV_LAT)) begin
                  if (blk_q < nblk_q - NB_BLK'(1)) begin
                     state_d = ST_NEXT;
                     chblk_d = 1'b1;
                     blk_d   = blk_q + NB_BLK'(1);
                     read_d  = '0;
                  end else begin
                     state_d = ST_DONE;
                     eop_d   = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_NEXT: state_d = ST_RUN;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Memory read latency is one cycle, so valid trails each RUN address.
   assign cval_d      = (state_q == ST_RUN) && !i_abort;
   assign busy_d      = (state_d != ST_IDLE);
   assign dly_flush_c = i_abort && (state_q != ST_IDLE);
   // Rows 0 and 1 only prime the window; the first result is row 2.
   assign dly_in_c    = (state_q == ST_RUN) && (read_q >= NB_ADDRESS'(2));

   always_ff @(posedge i_CLK or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         read_q  <= '0;
         len_q   <= '0;
         nblk_q  <= '0;
         blk_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         sop_q   <= 1'b0;
         chblk_q <= 1'b0;
         eop_q   <= 1'b0;
         busy_q  <= 1'b0;
         cval_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         read_q  <= read_d;
         len_q   <= len_d;
         nblk_q  <= nblk_d;
         blk_q   <= blk_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         sop_q   <= sop_d;
         chblk_q <= chblk_d;
         eop_q   <= eop_d;
         busy_q  <= busy_d;
         cval_q  <= cval_d;
      end
   end

   sched_delay #(
      .DEPTH (DLY_DEPTH),
      .IDX_W (NB_ADDRESS)
   ) u_delay (
      .clk_i   (i_CLK),
      .rst_i   (i_reset),
      .flush_i (dly_flush_c),
      .valid_i (dly_in_c),
      .idx_i   (read_q - NB_ADDRESS'(2)),
      .valid_o (o_we),
      .idx_o   (o_writeAdd)
   );

   assign o_readAdd    = read_q;
   assign o_conv_valid = cval_q;
   assign o_sop        = sop_q;
   assign o_chblk      = chblk_q;
   assign o_eop        = eop_q;
   assign o_busy       = busy_q;
   assign o_err        = err_q;
   assign o_blk_idx    = blk_q;

endmodule
